// File: rtl/alu_share_arbiter_if.sv
// Signal bundle for alu_share_arbiter: both request channels, the shared response and the ALU hookup.
// slave is the arbiter's view; master is the requesters' and ALU's view.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_f;
    logic             req0_branch;
    logic [2:0]       req0_bc;
    logic             resp0_valid;
    logic             resp0_ready;

    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_f;
    logic             req1_branch;
    logic [2:0]       req1_bc;
    logic             resp1_valid;
    logic             resp1_ready;

    // shared response
    logic [WIDTH-1:0] resp_y;
    logic             resp_zero;
    logic             resp_cout;

    // ALU datapath
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_f;
    logic             alu_branch;
    logic [2:0]       alu_bc;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_cout;

    // status
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f, req0_branch, req0_bc, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_f, req1_branch, req1_bc, resp1_ready,
        output req0_ready, resp0_valid, req1_ready, resp1_valid,
        output resp_y, resp_zero, resp_cout,
        output alu_a, alu_b, alu_f, alu_branch, alu_bc,
        input  alu_y, alu_zero, alu_cout,
        output busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_f, req0_branch, req0_bc, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_f, req1_branch, req1_bc, resp1_ready,
        input  req0_ready, resp0_valid, req1_ready, resp1_valid,
        input  resp_y, resp_zero, resp_cout,
        input  alu_a, alu_b, alu_f, alu_branch, alu_bc,
        output alu_y, alu_zero, alu_cout,
        input  busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU, register to register) -> RESP (return handshake).
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // operand registers feeding the ALU
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_f;
    logic             op_branch;
    logic [2:0]       op_bc;

    // ownership and fairness
    logic             owner;
    logic             last_grant;

    // result registers and counter
    logic [WIDTH-1:0] res_y;
    logic             res_zero;
    logic             res_cout;
    logic [CNT_W-1:0] count;

    logic             grant_id;
    logic             accept;
    logic             resp_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        grant_id  = 1'b0;
        accept    = 1'b0;
        resp_done = 1'b0;

        // On a tie the requester not served last wins; a lone requester always wins.
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req1_valid;
        end

        case (state)
            IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && !reset) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_done = owner ? bus.resp1_ready : bus.resp0_ready;
                if (resp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            op_f       <= 3'd0;
            op_branch  <= 1'b0;
            op_bc      <= 3'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_a       <= grant_id ? bus.req1_a      : bus.req0_a;
            op_b       <= grant_id ? bus.req1_b      : bus.req0_b;
            op_f       <= grant_id ? bus.req1_f      : bus.req0_f;
            op_branch  <= grant_id ? bus.req1_branch : bus.req0_branch;
            op_bc      <= grant_id ? bus.req1_bc     : bus.req0_bc;
            owner      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Results are captured only at the end of EXEC and stay frozen through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_y    <= '0;
            res_zero <= 1'b0;
            res_cout <= 1'b0;
            count    <= '0;
        end else if (state == EXEC) begin
            res_y    <= bus.alu_y;
            res_zero <= bus.alu_zero;
            res_cout <= bus.alu_cout;
            count    <= count + CNT_W'(1);
        end
    end

    // Ready is gated by reset so nothing is offered while reset is held.
    assign bus.req0_ready  = accept && !grant_id;
    assign bus.req1_ready  = accept &&  grant_id;
    assign bus.resp0_valid = (state == RESP) && !owner;
    assign bus.resp1_valid = (state == RESP) &&  owner;

    assign bus.resp_y      = res_y;
    assign bus.resp_zero   = res_zero;
    assign bus.resp_cout   = res_cout;

    assign bus.alu_a       = op_a;
    assign bus.alu_b       = op_b;
    assign bus.alu_f       = op_f;
    assign bus.alu_branch  = op_branch;
    assign bus.alu_bc      = op_bc;

    assign bus.busy        = (state != IDLE);
    assign bus.op_count    = count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU; counter narrowed to 4 bits to reach wrap.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    logic clk;
    logic reset;

    alu_share_arbiter_if #(.WIDTH(32), .CNT_W(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 000 and, 001 or, 010 add, 110 sub; branch 010 equal, 101 signed less-than.
    logic [32:0] alu_sum;
    logic [31:0] alu_res;
    always_comb begin
        alu_sum = 33'd0;
        alu_res = 32'd0;
        if (bus.alu_branch) begin
            case (bus.alu_bc)
                3'b010:  alu_res = {31'd0, bus.alu_a == bus.alu_b};
                3'b101:  alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
                default: alu_res = 32'd0;
            endcase
        end else begin
            case (bus.alu_f)
                3'b000:  alu_res = bus.alu_a & bus.alu_b;
                3'b001:  alu_res = bus.alu_a | bus.alu_b;
                3'b010:  begin alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};        alu_res = alu_sum[31:0]; end
                3'b110:  begin alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1; alu_res = alu_sum[31:0]; end
                default: alu_res = 32'd0;
            endcase
        end
    end
    assign bus.alu_y    = alu_res;
    assign bus.alu_cout = alu_sum[32];
    assign bus.alu_zero = (alu_res == 32'd0);

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_count;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic ready_of(input bit n);
        return n ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic resp_valid_of(input bit n);
        return n ? bus.resp1_valid : bus.resp0_valid;
    endfunction

    task automatic drive_req(input bit n, input bit v, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] f, input bit br, input logic [2:0] bc);
        if (n) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
            bus.req1_f = f; bus.req1_branch = br; bus.req1_bc = bc;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
            bus.req0_f = f; bus.req0_branch = br; bus.req0_bc = bc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 4'd0;
    endtask

    // One full operation from a negedge in IDLE; returns at the negedge after the response handshake.
    task automatic do_op(input string tag, input bit n, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input bit br, input logic [2:0] bc,
                         input logic [31:0] ey, input bit ez, input bit ec);
        int lat;
        drive_req(n, 1'b1, a, b, f, br, bc);
        #1;
        lat = 0;
        while (!ready_of(n) && lat < 8) begin
            @(negedge clk); #1; lat++;
        end
        check({tag, " accept"}, ready_of(n), 1'b1);
        @(negedge clk);
        drive_req(n, 1'b0, a, b, f, br, bc);
        lat = 1;
        while (!resp_valid_of(n) && lat < 8) begin
            @(negedge clk); lat++;
        end
        exp_count++;
        check({tag, " latency"}, lat, 2);
        check({tag, " y"}, bus.resp_y, ey);
        check({tag, " zero"}, bus.resp_zero, ez);
        check({tag, " cout"}, bus.resp_cout, ec);
        check({tag, " count"}, bus.op_count, exp_count);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        bit exp_owner;

        reset = 1'b1;
        exp_count = 4'd0;
        drive_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b010, 1'b0, 3'd0);
        drive_req(1'b1, 1'b1, 32'd6, 32'd3, 3'b000, 1'b0, 3'd0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;

        // Reset values, with both requesters asserting valid
        @(negedge clk); #1;
        check("rst req0_ready", bus.req0_ready, 1'b0);
        check("rst req1_ready", bus.req1_ready, 1'b0);
        check("rst resp0_valid", bus.resp0_valid, 1'b0);
        check("rst resp1_valid", bus.resp1_valid, 1'b0);
        check("rst resp_y", bus.resp_y, 32'd0);
        check("rst alu_a", bus.alu_a, 32'd0);
        check("rst alu_f", bus.alu_f, 3'd0);
        check("rst busy", bus.busy, 1'b0);
        check("rst op_count", bus.op_count, 4'd0);

        // Tie-break and fairness: both valid from reset release, six grants 0,1,0,1,0,1
        drive_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b001, 1'b0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_owner = k[0];
            cyc = 0;
            while (!(bus.req0_ready || bus.req1_ready) && cyc < 8) begin
                @(negedge clk); #1; cyc++;
            end
            check("tie grant1", bus.req1_ready, exp_owner);
            check("tie grant0", bus.req0_ready, !exp_owner);
            @(negedge clk);
            @(negedge clk);
            check("tie resp owner", resp_valid_of(exp_owner), 1'b1);
            check("tie resp y", bus.resp_y, exp_owner ? 32'd2 : 32'd3);
            @(negedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_count = 4'd6;
        check("tie count", bus.op_count, exp_count);

        // Single add after a fresh reset
        do_reset();
        do_op("add", 1'b0, 32'd5, 32'd7, 3'b010, 1'b0, 3'd0, 32'd12, 1'b0, 1'b0);
        check("add hold alu_a", bus.alu_a, 32'd5);
        check("add idle busy", bus.busy, 1'b0);

        // Subtract to zero, branch compares
        do_op("sub", 1'b1, 32'd9, 32'd9, 3'b110, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
        do_op("blt", 1'b0, 32'd3, 32'd8, 3'b000, 1'b1, 3'b101, 32'd1, 1'b0, 1'b0);
        do_op("beq", 1'b0, 32'd3, 32'd8, 3'b000, 1'b1, 3'b010, 32'd0, 1'b1, 1'b0);

        // Backpressure on requester 1 while requester 0 waits
        bus.resp1_ready = 1'b0;
        drive_req(1'b1, 1'b1, 32'd20, 32'd22, 3'b010, 1'b0, 3'd0);
        #1;
        check("bp accept1", bus.req1_ready, 1'b1);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 32'd20, 32'd22, 3'b010, 1'b0, 3'd0);
        drive_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010, 1'b0, 3'd0);
        @(negedge clk); #1;
        exp_count++;
        check("bp resp1_valid", bus.resp1_valid, 1'b1);
        check("bp count", bus.op_count, exp_count);
        for (int k = 0; k < 5; k++) begin
            check("bp y stable", bus.resp_y, 32'd42);
            check("bp flags stable", {bus.resp_zero, bus.resp_cout}, 2'b00);
            check("bp req0_ready", bus.req0_ready, 1'b0);
            check("bp busy", bus.busy, 1'b1);
            check("bp resp0_valid", bus.resp0_valid, 1'b0);
            @(negedge clk); #1;
        end
        bus.resp1_ready = 1'b1;
        #1;
        check("bp no accept on handshake", bus.req0_ready, 1'b0);
        @(negedge clk); #1;
        check("bp accept0 next", bus.req0_ready, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        exp_count++;
        check("bp resp0_valid", bus.resp0_valid, 1'b1);
        check("bp resp0 y", bus.resp_y, 32'd2);
        @(negedge clk);

        // Reset during EXEC discards the operation
        drive_req(1'b0, 1'b1, 32'd5, 32'd6, 3'b010, 1'b0, 3'd0);
        #1;
        check("rx accept", bus.req0_ready, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        check("rx in exec", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rx busy", bus.busy, 1'b0);
        check("rx alu_a", bus.alu_a, 32'd0);
        check("rx resp_y", bus.resp_y, 32'd0);
        check("rx count", bus.op_count, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 4'd0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp0_valid || bus.resp1_valid) seen++;
        end
        check("rx no response", seen, 0);

        // Counter wrap: 16 operations on a 4-bit counter ends at 0
        for (int k = 0; k < 16; k++) begin
            do_op("wrap", k[0], k, 32'd1, 3'b010, 1'b0, 3'd0, k + 1, 1'b0, 1'b0);
        end
        check("wrap final", bus.op_count, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that shares the single 32-bit `alu` datapath between two independent requesters, such as the execute stage and a branch/compare helper. It accepts one operation at a time through a valid/ready handshake, drives the ALU from registered operands for one cycle, and captures the result. It then returns the result to the originating requester through a second valid/ready handshake. Grants alternate round-robin under contention.

## Interface
- `WIDTH`, default 32: operand/result width. Must equal 32 to match `alu`.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester N has an operation.
- `req0_ready` / `req1_ready`  out  1  operation accepted on a cycle with valid&ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_f` / `req1_f`  in  3  ALU function code.
- `req0_branch` / `req1_branch`  in  1  branch-compare mode.
- `req0_bc` / `req1_bc`  in  3  branch compare select.
- `resp0_valid` / `resp1_valid`  out  1  result pending for requester N.
- `resp0_ready` / `resp1_ready`  in  1  requester N takes the result.
- `resp_y`  out  WIDTH  registered result, shared by both requesters.
- `resp_zero`, `resp_cout`  out  1  registered zero / carry flags.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a_in` / `b_in`.
- `alu_f`  out  3  to ALU `f_in`.
- `alu_branch`  out  1  to ALU `branch`.
- `alu_bc`  out  3  to ALU `branchcontrol`.
- `alu_y`  in  WIDTH  from ALU `y_out`.
- `alu_zero`, `alu_cout`  in  1  from ALU `zero` / `c_out`.
- `busy`  out  1  state is not IDLE.
- `op_count`  out  CNT_W  number of completed ALU operations.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- Grant selection happens only in IDLE and is combinational from the two valid inputs:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so req0 wins the first tie.
- `reqN_ready` is 1 only when the state is IDLE and N is granted. At most one ready is high in any cycle.
- On accept (IDLE and valid&ready):
  - Latch a, b, f, branch and bc into the operand registers.
  - Latch the owner ID.
  - Set `last_grant` to the owner.
  - Go to EXEC.
- The `alu_*` outputs are always driven from the operand registers. They hold their value outside EXEC.
- At the end of the EXEC cycle:
  - Capture `alu_y`, `alu_zero` and `alu_cout` into the `resp_*` registers.
  - Increment `op_count`. It wraps from all-ones to 0.
  - Go to RESP.
- In RESP:
  - `resp<owner>_valid` is 1 and the other resp_valid is 0.
  - `resp_y`, `resp_zero` and `resp_cout` stay stable until the handshake.
  - On `resp<owner>_ready`, go to IDLE.
  - The `resp_ready` of the non-owner is ignored.
- Requesters not granted keep valid asserted. Dropping valid before it is accepted is legal and leaves no side effect.
- Reset values (all asynchronous):
  - all `req*_ready` and `resp*_valid` are 0;
  - `resp_y`, `resp_zero` and `resp_cout` are 0;
  - all `alu_*` outputs are 0;
  - `busy` is 0 and `op_count` is 0.
- Reset asserted mid-operation discards the in-flight operation and its pending response. No response is produced, and the requester must reissue.

## Timing
- An accept on the edge ending cycle T puts EXEC in cycle T+1.
- The result registers update at the edge ending T+1. `resp_valid` is high from cycle T+2.
- Minimum latency from accept to `resp_valid` is 2 cycles.
- Minimum occupancy per operation is 3 cycles (IDLE, EXEC, RESP). With `resp_ready` tied high, sustained throughput is 1 operation per 3 cycles.
- No new accept is allowed in the same cycle as the response handshake. The next accept is possible in the IDLE cycle that follows.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- The ALU is purely combinational within the EXEC cycle. Its path runs register to register: operand registers, then ALU, then result registers.

## Test plan
- **Single add.** After reset, req0: a=5, b=7, f=010, branch=0 for one cycle, accepted at T.
  - `resp0_valid` rises at T+2 with `resp_y`=12, zero=0, cout=0.
  - `op_count`=1.
- **Tie-break and fairness.** req0 (a=1, b=2, f=001) and req1 (a=6, b=3, f=000) held valid together from reset release.
  - req0 is accepted first, with `resp_y`=3.
  - req1 is accepted next, with `resp_y`=2.
  - Keep both valid for 4 more operations: grants alternate.
- **Subtract to zero.** req1: a=9, b=9, f=110 gives `resp_y`=0, `resp_zero`=1, `resp_cout`=1.
- **Branch compare.** req0: branch=1, bc=101, a=3, b=8 gives `resp_y`=1, zero=0. Then bc=010 with the same operands gives `resp_y`=0, zero=1.
- **Backpressure.** Hold `resp1_ready`=0 for 5 cycles while req0 is valid.
  - `resp_*` is stable throughout.
  - `req0_ready`=0 and `busy`=1 throughout.
  - `resp0_valid`=0 throughout.
  - After `resp1_ready`=1, req0 is accepted 1 cycle later.
- **Reset and wrap.** Assert `reset` during EXEC: all outputs take their reset values immediately and no `resp_valid` follows. Separately, with `CNT_W`=4, run 16 operations: `op_count` goes 15 then 0.
